// File: rtl/mac_accum.sv
// Signed multiply-accumulate reducer: sums 16-bit products into an ACC_W result
// per vector, with a valid/ready result handshake. Define MAC_ACCUM_SAT_EN to make
// overflowing sums saturate instead of wrapping.
module mac_accum #(
    parameter int ACC_W   = 24,
    parameter int MAX_LEN = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      prod_in,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [8:0]       cnt_out,
    output logic             ovf,
    output logic             len_err,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SUM_W = ACC_W + 1;
    localparam logic [8:0] LAST_CNT = 9'(MAX_LEN - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    typedef struct packed {
        logic signed [ACC_W-1:0] acc;
        logic [8:0]              cnt;
        logic                    ovf;
        logic                    len_err;
    } result_t;

    state_t  state, state_nxt;
    result_t res, res_nxt;

    logic signed [15:0]      prod_s;
    logic signed [SUM_W-1:0] sum_x;
    logic                    sum_ovf;
    logic signed [ACC_W-1:0] sum_res;
    logic                    beat;
    logic                    term;

    // Exact sum one bit wider than the accumulator; the top two bits disagree
    // exactly when the true value falls outside the signed ACC_W range.
    always_comb begin
        prod_s  = $signed(prod_in);
        sum_x   = SUM_W'(res.acc) + SUM_W'(prod_s);
        sum_ovf = sum_x[ACC_W] ^ sum_x[ACC_W-1];
`ifdef MAC_ACCUM_SAT_EN
        if (sum_ovf) begin
            sum_res = sum_x[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            sum_res = sum_x[ACC_W-1:0];
        end
`else
        sum_res = sum_x[ACC_W-1:0];
`endif
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign beat      = in_valid && in_ready;
    assign term      = in_last || (res.cnt == LAST_CNT);

    always_comb begin
        state_nxt = state;
        res_nxt   = res;
        case (state)
            ACCUM: begin
                if (beat) begin
                    res_nxt.acc = sum_res;
                    res_nxt.cnt = res.cnt + 9'd1;
                    res_nxt.ovf = res.ovf | sum_ovf;
                    if (term) begin
                        state_nxt       = DONE;
                        res_nxt.len_err = !in_last;
                    end
                end
            end
            DONE: begin
                // Result is frozen until consumed; upstream beats wait.
                if (out_ready) begin
                    state_nxt = ACCUM;
                    res_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ACCUM;
                res_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
            res   <= '0;
        end else begin
            state <= state_nxt;
            res   <= res_nxt;
        end
    end

    assign acc_out = res.acc;
    assign cnt_out = res.cnt;
    assign ovf     = res.ovf;
    assign len_err = res.len_err;

endmodule

// File: tb/tb_mac_accum.sv
// Directed bench for mac_accum (ACC_W=17, MAX_LEN=4) with a transaction-level
// reference model checked every cycle plus literal expectations per vector.
module tb_mac_accum;

    localparam int W  = 17;
    localparam int ML = 4;
    localparam longint MAXV = (longint'(1) <<< (W - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (W - 1));
    localparam longint MODV = longint'(1) <<< W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   prod_in = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b1;
    logic          in_ready;
    logic [W-1:0]  acc_out;
    logic [8:0]    cnt_out;
    logic          ovf;
    logic          len_err;
    logic          out_valid;

    mac_accum #(.ACC_W(W), .MAX_LEN(ML)) dut (
        .clk(clk), .rst(rst), .prod_in(prod_in), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .acc_out(acc_out),
        .cnt_out(cnt_out), .ovf(ovf), .len_err(len_err),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint acc_s();
        return longint'($signed(acc_out));
    endfunction

    // Reference model: running integer sum of the current vector.
    longint m_sum = 0;
    longint m_e;
    int     m_cnt = 0;
    bit     m_done = 1'b0;
    bit     m_ovf = 1'b0;
    bit     m_len = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_sum = 0; m_cnt = 0; m_done = 0; m_ovf = 0; m_len = 0;
        end else if (m_done) begin
            if (out_ready) begin
                m_sum = 0; m_cnt = 0; m_done = 0; m_ovf = 0; m_len = 0;
            end
        end else if (in_valid) begin
            m_e = m_sum + longint'($signed(prod_in));
            if (m_e > MAXV || m_e < MINV) begin
                m_ovf = 1;
`ifdef MAC_ACCUM_SAT_EN
                m_e = (m_e > MAXV) ? MAXV : MINV;
`else
                m_e = m_e & (MODV - 1);
                if (m_e > MAXV) m_e = m_e - MODV;
`endif
            end
            m_sum = m_e;
            m_cnt++;
            if (in_last || m_cnt == ML) begin
                m_done = 1;
                m_len  = !in_last;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl in_ready", in_ready, !m_done);
            check("mdl out_valid", out_valid, m_done);
            if (m_done) begin
                check("mdl acc_out", acc_s(), m_sum);
                check("mdl cnt_out", cnt_out, m_cnt);
                check("mdl ovf", ovf, m_ovf);
                check("mdl len_err", len_err, m_len);
            end
        end
    end

    // Present one beat and hold it until accepted; returns 1 time unit after
    // the accepting edge.
    task automatic send(input logic [15:0] p, input bit last);
        int n = 0;
        bit rdy;
        prod_in  = p;
        in_last  = last;
        in_valid = 1'b1;
        do begin
            rdy = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) begin
            tests++; fails++;
            $display("FAIL send_timeout: beat not accepted, got in_ready=0, expected 1");
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after the terminating beat: result must already be valid.
    task automatic result(input string name, input longint acc, input int cnt,
                          input bit o, input bit le, input bit step);
        check({name, " out_valid"}, out_valid, 1);
        check({name, " acc_out"}, acc_s(), acc);
        check({name, " cnt_out"}, cnt_out, cnt);
        check({name, " ovf"}, ovf, o);
        check({name, " len_err"}, len_err, le);
        if (step) begin
            @(posedge clk); #1;
            check({name, " cleared in_ready"}, in_ready, 1);
            check({name, " cleared cnt"}, cnt_out, 0);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, " in_ready"}, in_ready, 1);
        check({name, " out_valid"}, out_valid, 0);
        check({name, " acc_out"}, acc_s(), 0);
        check({name, " cnt_out"}, cnt_out, 0);
        check({name, " ovf"}, ovf, 0);
        check({name, " len_err"}, len_err, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst    = 1'b0;
        chk_en = 1'b1;

        // Basic dot product, latency 1
        send(16'd100, 0);
        send(-16'sd50, 0);
        send(16'd7, 1);
        result("basic", 57, 3, 0, 0, 1);

        // Positive overflow at ACC_W=17
        send(16'd32767, 0);
        send(16'd32767, 0);
        send(16'd32767, 1);
`ifdef MAC_ACCUM_SAT_EN
        result("ovf_pos", 65535, 3, 1, 0, 1);
`else
        result("ovf_pos", -32771, 3, 1, 0, 1);
`endif

        // Negative overflow, further push on 4th beat (in_last at MAX_LEN)
        for (int i = 0; i < 3; i++) send(16'h8000, 0);
        send(16'h8000, 1);
`ifdef MAC_ACCUM_SAT_EN
        result("ovf_neg", -65536, 4, 1, 0, 1);
`else
        result("ovf_neg", 0, 4, 1, 0, 1);
`endif

        // Single beat, most negative product; ovf cleared from previous vector
        send(16'h8000, 1);
        result("single", -32768, 1, 0, 0, 1);

        // Truncation at MAX_LEN; 5th beat waits through DONE
        for (int i = 0; i < 4; i++) send(16'd1, 0);
        result("trunc", 4, 4, 0, 1, 0);
        send(16'd1, 0);
        send(16'd1, 1);
        result("after_trunc", 2, 2, 0, 0, 1);

        // Result held under backpressure while upstream keeps in_valid high
        out_ready = 1'b0;
        send(16'd10, 0);
        send(-16'sd3, 1);
        result("hold", 7, 2, 0, 0, 0);
        prod_in  = 16'd99;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold in_ready", in_ready, 0);
            check("hold out_valid", out_valid, 1);
            check("hold acc_out", acc_s(), 7);
            check("hold cnt_out", cnt_out, 2);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_idle("release");

        // Reset mid-vector discards the partial sum
        send(16'd1, 0);
        send(16'd2, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle("mid_rst");
        rst = 1'b0;
        send(16'd3, 0);
        send(16'd4, 1);
        result("post_rst", 7, 2, 0, 0, 1);

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
